// File: rtl/ldl_fifo_wr_arb.sv
// Round-robin write arbiter: N producers share one FIFO write side.
// One winner per cycle is registered onto we/wd/wsrc. Grants are throttled
// on the write side's full/wcnt, keeping one slot for the write in flight.
// Each requester may hold the grant for up to BURST consecutive cycles
// while another enabled requester waits.
module ldl_fifo_wr_arb #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int BURST = 4,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    en,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] din,
    output logic [N-1:0]    gnt,
    input  logic            full,
    input  logic [AW-1:0]   wcnt,
    output logic            we,
    output logic [DW-1:0]   wd,
    output logic [SW-1:0]   wsrc,
    output logic            busy
);

    localparam int            CW      = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW:0]   BURST_V = (CW+1)'(BURST);
    localparam logic [SW:0]   N_V     = (SW+1)'(N);

    // Arbiter state: last owner, grants already given in its current burst,
    // and whether the owner pointer refers to a real grant (cleared by reset
    // so that the first arbitration searches from requester 0).
    logic [SW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_live;

    // Output stage registers.
    logic          r_we;
    logic [DW-1:0] r_wd;
    logic [SW-1:0] r_wsrc;

    logic [N-1:0]  w_elig;
    logic          w_any;
    logic          w_ok;
    logic          w_grant;
    logic          w_keep;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]  w_rot;
    logic [SW:0]   w_shamt;
    logic [SW:0]   w_off;
    logic [SW:0]   w_sum;
    logic [SW-1:0] w_next;
    logic [SW-1:0] w_win;
    logic [DW-1:0] w_slice [N];
    logic [DW-1:0] w_win_data;

    assign w_elig = req & en;
    assign w_any  = |w_elig;

    // The registered we lands on the write side next cycle, so when the
    // FIFO shows one free slot and a write is already in flight, hold off.
    assign w_ok    = !full && !(r_we && (wcnt == {AW{1'b1}}));
    assign w_grant = w_ok && w_any && !rst;

    // Current owner keeps the grant while it still asks and has burst left.
    assign w_keep = r_live && w_elig[r_ptr] &&
                    (({1'b0, r_cnt} + 1'b1) < BURST_V);

    // Rotate the eligible set so bit 0 is the requester right after ptr;
    // the search wraps all the way round to ptr itself last.
    assign w_dbl   = {w_elig, w_elig};
    assign w_shamt = {1'b0, r_ptr} + 1'b1;
    assign w_rot   = N'(w_dbl >> w_shamt);

    // Find the nearest eligible requester after the current owner.
    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (SW+1)'(k);
            end
        end
    end

    assign w_sum  = {1'b0, r_ptr} + 1'b1 + w_off;
    assign w_next = (w_sum >= N_V) ? SW'(w_sum - N_V) : SW'(w_sum);
    assign w_win  = w_keep ? r_ptr : w_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign w_slice[gi] = din[gi*DW +: DW];
            assign gnt[gi]     = w_grant && (w_win == SW'(gi));
        end
    endgenerate

    assign w_win_data = w_slice[w_win];
    assign busy       = !rst && |(w_elig & ~gnt);

    // Track the owner and its burst length; a fresh search restarts the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= SW'(N - 1);
            r_cnt  <= '0;
            r_live <= 1'b0;
        end else if (w_grant) begin
            r_live <= 1'b1;
            if (w_keep) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                r_ptr <= w_win;
            end
        end
    end

    // Register the winner's data and index onto the write side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_wd   <= '0;
            r_wsrc <= '0;
        end else begin
            r_we <= w_grant;
            if (w_grant) begin
                r_wd   <= w_win_data;
                r_wsrc <= w_win;
            end
        end
    end

    assign we   = r_we;
    assign wd   = r_wd;
    assign wsrc = r_wsrc;

endmodule

// File: tb/tb_ldl_fifo_wr_arb.sv
// Bench for ldl_fifo_wr_arb: a BURST=4 instance on a depth-8 FIFO model and
// a BURST=1 instance on an always-empty write side, both checked every cycle
// against a run-length round-robin reference model plus directed checks.
module tb_ldl_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en, req;
    logic [31:0] din;
    logic [3:0]  gnt_a, gnt_b;
    logic        full_a, full_b;
    logic [2:0]  wcnt_a, wcnt_b;
    logic        we_a, we_b, busy_a, busy_b;
    logic [7:0]  wd_a, wd_b;
    logic [1:0]  wsrc_a, wsrc_b;

    ldl_fifo_wr_arb #(.N(4), .DW(8), .AW(3), .BURST(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .din(din), .gnt(gnt_a),
        .full(full_a), .wcnt(wcnt_a), .we(we_a), .wd(wd_a), .wsrc(wsrc_a),
        .busy(busy_a));

    ldl_fifo_wr_arb #(.N(4), .DW(8), .AW(3), .BURST(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .en(en), .req(req), .din(din), .gnt(gnt_b),
        .full(full_b), .wcnt(wcnt_b), .we(we_b), .wd(wd_b), .wsrc(wsrc_b),
        .busy(busy_b));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fcnt = 0;
    int rd_pulse = 0;
    bit rd_on = 1'b1;
    bit rand_mode = 1'b0;

    // Reference model: last owner (-1 = none) and length of its current run.
    int          burst_of [2] = '{4, 1};
    int          m_last [2];
    int          m_run  [2];
    int          m_win  [2];
    bit          m_cont [2];
    logic        m_we   [2];
    logic [7:0]  m_wd   [2];
    int          m_wsrc [2];

    logic [3:0]  s_gnt_a, s_gnt_b;
    logic        s_we_a;
    logic [1:0]  s_wsrc_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int w);
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = -1; m_run[k] = 0; m_win[k] = -1; m_cont[k] = 0;
            m_we[k] = 1'b0; m_wd[k] = 8'h00; m_wsrc[k] = 0;
        end
    endtask

    task automatic model_eval(input int k, input logic ok);
        logic [3:0] e;
        e = req & en;
        m_win[k]  = -1;
        m_cont[k] = 0;
        if (ok && e != 4'b0000) begin
            if (m_last[k] >= 0 && e[m_last[k]] && m_run[k] < burst_of[k]) begin
                m_win[k]  = m_last[k];
                m_cont[k] = 1;
            end else begin
                for (int s = 1; s <= 4; s++) begin
                    int idx;
                    idx = (m_last[k] + s + 4) % 4;
                    if (m_win[k] < 0 && e[idx]) m_win[k] = idx;
                end
            end
        end
    endtask

    task automatic model_commit(input int k);
        if (m_win[k] >= 0) begin
            m_run[k]  = m_cont[k] ? m_run[k] + 1 : 1;
            m_last[k] = m_win[k];
            m_wd[k]   = din[m_win[k]*8 +: 8];
            m_wsrc[k] = m_win[k];
        end
        m_we[k] = (m_win[k] >= 0);
    endtask

    // One clock: check at negedge+1, advance model at posedge, drive at negedge.
    task automatic cycle();
        logic       ok_a, ok_b, rd;
        logic [3:0] e, ga, gb;
        #1;
        ok_a = !full_a && !(m_we[0] && wcnt_a == 3'd7);
        ok_b = !full_b && !(m_we[1] && wcnt_b == 3'd7);
        model_eval(0, ok_a);
        model_eval(1, ok_b);
        e  = req & en;
        ga = onehot(m_win[0]);
        gb = onehot(m_win[1]);
        chk($sformatf("c%0d gnt_a", cyc), 32'(gnt_a), 32'(ga));
        chk($sformatf("c%0d busy_a", cyc), 32'(busy_a), 32'(|(e & ~ga)));
        chk($sformatf("c%0d we_a", cyc), 32'(we_a), 32'(m_we[0]));
        chk($sformatf("c%0d wd_a", cyc), 32'(wd_a), 32'(m_wd[0]));
        chk($sformatf("c%0d wsrc_a", cyc), 32'(wsrc_a), 32'(m_wsrc[0]));
        chk($sformatf("c%0d gnt_b", cyc), 32'(gnt_b), 32'(gb));
        chk($sformatf("c%0d busy_b", cyc), 32'(busy_b), 32'(|(e & ~gb)));
        chk($sformatf("c%0d we_b", cyc), 32'(we_b), 32'(m_we[1]));
        chk($sformatf("c%0d wd_b", cyc), 32'(wd_b), 32'(m_wd[1]));
        chk($sformatf("c%0d wsrc_b", cyc), 32'(wsrc_b), 32'(m_wsrc[1]));
        chk($sformatf("c%0d we_while_full", cyc), 32'(we_a & full_a), 32'd0);
        s_gnt_a  = gnt_a;
        s_gnt_b  = gnt_b;
        s_we_a   = we_a;
        s_wsrc_a = wsrc_a;
        $display("cyc %0d en=%b req=%b gnt_a=%b we_a=%b wd_a=%h wsrc_a=%0d fifo=%0d gnt_b=%b wd_b=%h",
                 cyc, en, req, gnt_a, we_a, wd_a, wsrc_a, fcnt, gnt_b, wd_b);
        @(posedge clk);
        model_commit(0);
        model_commit(1);
        rd   = (rd_on || rd_pulse > 0) && fcnt > 0;
        fcnt = fcnt + int'(s_we_a) - int'(rd);
        if (rd && rd_pulse > 0) rd_pulse--;
        @(negedge clk);
        full_a = (fcnt >= 8);
        wcnt_a = full_a ? 3'd0 : 3'(fcnt);
        for (int i = 0; i < 4; i++) begin
            if (m_win[0] == i) begin
                din[i*8 +: 8] = 8'($urandom);
                if (rand_mode) req[i] = 1'($urandom_range(0, 1));
            end else if (rand_mode && !req[i]) begin
                req[i] = ($urandom_range(0, 2) == 0);
                din[i*8 +: 8] = 8'($urandom);
            end
        end
        if (rand_mode) begin
            rd_on = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) en = 4'($urandom);
        end
        cyc++;
    endtask

    initial begin
        int  g;
        bit  found;
        rst = 1'b1; en = 4'b1111; req = 4'b1111; din = $urandom;
        full_a = 1'b0; wcnt_a = 3'd0; full_b = 1'b0; wcnt_b = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst gnt_a", 32'(gnt_a), 32'd0);
        chk("rst busy_a", 32'(busy_a), 32'd0);
        chk("rst we_a", 32'(we_a), 32'd0);
        chk("rst wd_a", 32'(wd_a), 32'd0);
        chk("rst wsrc_a", 32'(wsrc_a), 32'd0);
        chk("rst gnt_b", 32'(gnt_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All four requesting: bursts of four on A, strict rotation on B.
        for (int c = 0; c < 16; c++) begin
            cycle();
            chk($sformatf("p1 seq%0d", c), 32'(s_gnt_a), 32'(onehot(c / 4)));
            chk($sformatf("p1 we%0d", c), 32'(s_we_a), (c > 0) ? 32'd1 : 32'd0);
            if (c > 0) chk($sformatf("p1 wsrc%0d", c), 32'(s_wsrc_a), 32'((c - 1) / 4));
            chk($sformatf("p1 rot%0d", c), 32'(s_gnt_b), 32'(onehot(c % 4)));
        end

        // Run into requester 3's burst, then reset in the middle of it.
        repeat (14) cycle();
        chk("p2 owner3", 32'(s_gnt_a), 32'b1000);
        rst = 1'b1;
        #1;
        chk("p2 rst we_a", 32'(we_a), 32'd0);
        chk("p2 rst gnt_a", 32'(gnt_a), 32'd0);
        chk("p2 rst busy_a", 32'(busy_a), 32'd0);
        chk("p2 rst we_b", 32'(we_b), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("p2 first after rst", 32'(s_gnt_a), 32'b0001);

        // Single requester: granted every cycle, no bubbles.
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("p3 g2 %0d", i), 32'(s_gnt_a), 32'b0100);
            if (i > 0) chk($sformatf("p3 we %0d", i), 32'(s_we_a), 32'd1);
        end

        // Enables 1010: only 1 and 3 win; drop en[3] mid-burst of 3.
        en = 4'b1010; req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk($sformatf("p4 mask %0d", i), 32'(s_gnt_a & 4'b0101), 32'd0);
            chk($sformatf("p4 any %0d", i), 32'(s_gnt_a != 4'b0000), 32'd1);
        end
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            cycle();
            if (s_gnt_a == 4'b1000 && m_run[0] < 4) found = 1'b1;
        end
        chk("p4 found3", 32'(found), 32'd1);
        en = 4'b0010;
        cycle();
        chk("p4 moved to 1", 32'(s_gnt_a), 32'b0010);

        // Fill test: drain, stall reader, requester 0 continuous.
        en = 4'b1111; req = 4'b0000; rd_on = 1'b1;
        repeat (4) cycle();
        chk("p5 empty", 32'(fcnt), 32'd0);
        rd_on = 1'b0; req = 4'b0001; g = 0;
        repeat (16) begin
            cycle();
            g += int'(s_gnt_a[0]);
        end
        chk("p5 grants", 32'(g), 32'd8);
        chk("p5 full", 32'(full_a), 32'd1);
        rd_pulse = 1; g = 0;
        repeat (6) begin
            cycle();
            g += int'(s_gnt_a[0]);
        end
        chk("p5 one per slot", 32'(g), 32'd1);

        // Randomised traffic with random enables and a throttled reader.
        rand_mode = 1'b1; rd_on = 1'b1;
        repeat (300) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
